// File: rtl/piso_stream.sv
// Parallel-in/serial-out serializer with valid/ready on both sides.
// Bit order is chosen per word; a new word can load on the last bit's transfer.
module piso_stream #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_lsb_first,
    output logic             serial_out,
    output logic             serial_valid,
    input  logic             out_ready,
    output logic             frame_last,
    output logic             busy
);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lsb_q, lsb_d;
    logic               load;
    logic               xfer;

    assign busy         = (state_q == StShift);
    assign serial_valid = busy;
    assign serial_out   = busy ? (lsb_q ? sreg_q[0] : sreg_q[WIDTH-1]) : 1'b0;
    assign frame_last   = busy && (cnt_q == CNT_W'(WIDTH - 1));
    // Combinational out_ready -> in_ready path gives gap-free back-to-back framing.
    assign in_ready     = !flush && (!busy || (frame_last && out_ready));
    assign load         = in_valid && in_ready;
    assign xfer         = busy && out_ready;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        lsb_d   = lsb_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (load) begin
            state_d = StShift;
            sreg_d  = in_data;
            lsb_d   = in_lsb_first;
            cnt_d   = '0;
        end else if (xfer) begin
            sreg_d = lsb_q ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0};
            if (frame_last) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            lsb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            lsb_q   <= lsb_d;
        end
    end

endmodule
